// File: rtl/seven_seg_if.sv
// Signal bundle between the seven-segment scanner and its controller/display side.
interface seven_seg_if;
  logic       enable;
  logic [7:0] digit_mask;
  logic [7:0] anode_select;
  logic [2:0] digit_idx;
  logic       digit_strobe;

  modport master (
    output enable,
    output digit_mask,
    input  anode_select,
    input  digit_idx,
    input  digit_strobe
  );

  modport slave (
    input  enable,
    input  digit_mask,
    output anode_select,
    output digit_idx,
    output digit_strobe
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed anode scanner for an 8-digit common-anode display, with
// per-slot anti-ghosting blanking, per-digit masking and a slot-start strobe.
module seven_seg_scanner #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_CYCLES    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  seven_seg_if.slave  bus
);

  localparam int            CW   = $clog2(TICKS_PER_DIGIT);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_DIGIT - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    mask_q;
  logic          active;
  logic          lit_window;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      mask_q <= '0;
      active <= 1'b0;
    end else if (!bus.enable) begin
      cnt    <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (!active) begin
      // First enabled edge opens slot 0 and latches the mask for it.
      active <= 1'b1;
      cnt    <= '0;
      idx    <= '0;
      mask_q <= bus.digit_mask;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      idx    <= idx + 3'd1;
      mask_q <= bus.digit_mask;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With no blanking the comparison would be constant, so it is elided.
  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign lit_window = 1'b1;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
      assign lit_window = (cnt >= BLANK);
    end
  endgenerate

  always_comb begin
    bus.anode_select = 8'hFF;
    if (active && lit_window && mask_q[idx])
      bus.anode_select = ~(8'h01 << idx);
  end

  assign bus.digit_idx    = idx;
  assign bus.digit_strobe = active && (cnt == '0);

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: two instances, blanked (2) and unblanked (0).
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  logic rst;

  seven_seg_if s0 ();
  seven_seg_if s1 ();

  seven_seg_scanner #(.TICKS_PER_DIGIT(10), .BLANK_CYCLES(2)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (s0)
  );

  seven_seg_scanner #(.TICKS_PER_DIGIT(10), .BLANK_CYCLES(0)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (s1)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] seq [8];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check anode, index and strobe of the blanked instance.
  task automatic chk0(input string tag, input logic [7:0] a, input logic [2:0] i, input logic s);
    chk({tag, " anode"},  s0.anode_select,         a);
    chk({tag, " idx"},    {5'd0, s0.digit_idx},    {5'd0, i});
    chk({tag, " strobe"}, {7'd0, s0.digit_strobe}, {7'd0, s});
  endtask

  task automatic go(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Drop enable for one cycle, then re-arm with the given mask; cyc=0 is the first active cycle.
  task automatic restart(input logic [7:0] m);
    s0.enable = 1'b0;
    @(negedge clk);
    s0.enable     = 1'b1;
    s0.digit_mask = m;
    cyc = -1;
    go(0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    rst           = 1'b1;
    s0.enable     = 1'b0;
    s0.digit_mask = 8'hFF;
    s1.enable     = 1'b0;
    s1.digit_mask = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    chk0("reset", 8'hFF, 3'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk0("idle", 8'hFF, 3'd0, 1'b0);

    // Full mask scan
    s0.enable = 1'b1;
    cyc = -1;
    go(0);  chk0("t1 c0",  8'hFF, 3'd0, 1'b1);
    go(1);  chk0("t1 c1",  8'hFF, 3'd0, 1'b0);
    go(2);  chk0("t1 c2",  8'hFE, 3'd0, 1'b0);
    go(9);  chk0("t1 c9",  8'hFE, 3'd0, 1'b0);
    go(10); chk0("t1 c10", 8'hFF, 3'd1, 1'b1);
    go(11); chk0("t1 c11", 8'hFF, 3'd1, 1'b0);
    go(12); chk0("t1 c12", 8'hFD, 3'd1, 1'b0);
    go(19); chk0("t1 c19", 8'hFD, 3'd1, 1'b0);
    go(22); chk0("t1 c22", 8'hFB, 3'd2, 1'b0);
    go(45); chk0("t1 c45", 8'hEF, 3'd4, 1'b0);
    go(72); chk0("t1 c72", 8'h7F, 3'd7, 1'b0);
    go(79); chk0("t1 c79", 8'h7F, 3'd7, 1'b0);
    go(80); chk0("t1 c80", 8'hFF, 3'd0, 1'b1);
    go(82); chk0("t1 c82", 8'hFE, 3'd0, 1'b0);

    // Alternate digits masked
    restart(8'b1010_1010);
    chk0("t2 c0", 8'hFF, 3'd0, 1'b1);
    go(5);  chk0("t2 c5",  8'hFF, 3'd0, 1'b0);
    go(9);  chk0("t2 c9",  8'hFF, 3'd0, 1'b0);
    go(10); chk0("t2 c10", 8'hFF, 3'd1, 1'b1);
    go(12); chk0("t2 c12", 8'hFD, 3'd1, 1'b0);
    go(25); chk0("t2 c25", 8'hFF, 3'd2, 1'b0);
    go(30); chk0("t2 c30", 8'hFF, 3'd3, 1'b1);
    go(35); chk0("t2 c35", 8'hF7, 3'd3, 1'b0);
    go(45); chk0("t2 c45", 8'hFF, 3'd4, 1'b0);
    go(55); chk0("t2 c55", 8'hDF, 3'd5, 1'b0);
    go(65); chk0("t2 c65", 8'hFF, 3'd6, 1'b0);
    go(77); chk0("t2 c77", 8'h7F, 3'd7, 1'b0);

    // Mask change mid-slot only applies from the next slot
    restart(8'hFF);
    go(5);  chk0("t3 c5", 8'hFE, 3'd0, 1'b0);
    s0.digit_mask = 8'h00;
    go(6);  chk0("t3 c6",  8'hFE, 3'd0, 1'b0);
    go(9);  chk0("t3 c9",  8'hFE, 3'd0, 1'b0);
    go(10); chk0("t3 c10", 8'hFF, 3'd1, 1'b1);
    go(12); chk0("t3 c12", 8'hFF, 3'd1, 1'b0);
    go(19); chk0("t3 c19", 8'hFF, 3'd1, 1'b0);

    // Drop enable mid-slot 3
    restart(8'hFF);
    go(36); chk0("t4 c36", 8'hF7, 3'd3, 1'b0);
    s0.enable = 1'b0;
    @(negedge clk);
    chk0("t4 off", 8'hFF, 3'd0, 1'b0);
    @(negedge clk);
    chk0("t4 off2", 8'hFF, 3'd0, 1'b0);
    s0.enable = 1'b1;
    cyc = -1;
    go(0);  chk0("t4 re c0", 8'hFF, 3'd0, 1'b1);
    go(2);  chk0("t4 re c2", 8'hFE, 3'd0, 1'b0);

    // Asynchronous reset between clock edges
    go(55); chk0("t5 c55", 8'hDF, 3'd5, 1'b0);
    #2 rst = 1'b1;
    #1 chk0("t5 async", 8'hFF, 3'd0, 1'b0);
    @(negedge clk);
    chk0("t5 held", 8'hFF, 3'd0, 1'b0);
    rst = 1'b0;
    cyc = -1;
    go(0);  chk0("t5 rel c0", 8'hFF, 3'd0, 1'b1);
    go(2);  chk0("t5 rel c2", 8'hFE, 3'd0, 1'b0);
    go(12); chk0("t5 rel c12", 8'hFD, 3'd1, 1'b0);

    // No blanking: every cycle of every slot lit
    s0.enable = 1'b0;
    s1.enable = 1'b1;
    cyc = -1;
    for (int slot = 0; slot < 8; slot++) begin
      for (int k = 0; k < 10; k++) begin
        go(slot * 10 + k);
        chk($sformatf("t6 s%0d k%0d anode", slot, k), s1.anode_select, seq[slot]);
        if (k == 0)
          chk($sformatf("t6 s%0d strobe", slot), {7'd0, s1.digit_strobe}, 8'd1);
      end
    end
    go(80);
    chk("t6 wrap anode",  s1.anode_select,         8'hFE);
    chk("t6 wrap strobe", {7'd0, s1.digit_strobe}, 8'd1);
    chk("t6 wrap idx",    {5'd0, s1.digit_idx},    8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
